// File: rtl/rx_xgmii_align.sv
// rx_xgmii_align: XGMII receive front end ahead of the CRC checker.
// Finds /S/, strips preamble/SFD, realigns to lane 0, locates /T/.
module rx_xgmii_align #(
  parameter bit START_LANE4_EN = 1'b1,
  parameter bit CHECK_PREAMBLE = 1'b1
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic [63:0] crc_data,
  output logic        receiving,
  output logic        receiving_d1,
  output logic        receiving_d2,
  output logic        get_terminator,
  output logic [2:0]  terminator_location,
  output logic        code_error,
  output logic        preamble_error
);

  typedef enum logic [1:0] {
    IDLE,
    PRE_HI,
    DATA,
    TAIL
  } state_t;

  state_t      state_q;
  logic [63:0] cur_q;
  logic [7:0]  curc_q;
  logic [31:0] prev_hi_q;
  logic        align_q;
  logic [2:0]  tloc_q;

  logic [63:0] aligned;
  logic [2:0]  k_lane;
  logic        term_hit;
  logic [2:0]  term_loc;
  logic        s0, s4;
  logic        pre0_ok, pre4_ok, prehi_ok;

  function automatic logic [63:0] mask_bytes(
    input logic [63:0] d,
    input logic [2:0]  n
  );
    logic [63:0] r;
    r = d;
    for (int i = 0; i < 8; i++)
      if (i >= int'(n)) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  assign aligned = align_q ? {cur_q[31:0], prev_hi_q} : cur_q;

  // lowest control lane of the current word
  always_comb begin
    k_lane = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (curc_q[i]) k_lane = 3'(i);
  end

  assign term_hit = cur_q[{k_lane, 3'b000} +: 8] == 8'hFD;
  assign term_loc = align_q ? {1'b1, k_lane[1:0]} : k_lane;

  assign s0 = curc_q[0] && cur_q[7:0] == 8'hFB;
  assign s4 = START_LANE4_EN && curc_q[4] &&
              cur_q[39:32] == 8'hFB;

  assign pre0_ok = curc_q == 8'h01 &&
    (!CHECK_PREAMBLE ||
     cur_q[63:8] == {8'hD5, {6{8'h55}}});
  assign pre4_ok = curc_q[7:4] == 4'h1 &&
    (!CHECK_PREAMBLE ||
     cur_q[63:40] == {3{8'h55}});
  assign prehi_ok = curc_q == 8'h00 &&
    (!CHECK_PREAMBLE ||
     cur_q[31:0] == {8'hD5, {3{8'h55}}});

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q             <= IDLE;
      cur_q               <= '0;
      curc_q              <= '0;
      prev_hi_q           <= '0;
      align_q             <= 1'b0;
      tloc_q              <= '0;
      crc_data            <= '0;
      receiving           <= 1'b0;
      receiving_d1        <= 1'b0;
      receiving_d2        <= 1'b0;
      get_terminator      <= 1'b0;
      terminator_location <= '0;
      code_error          <= 1'b0;
      preamble_error      <= 1'b0;
    end else begin
      cur_q               <= rxd;
      curc_q              <= rxc;
      prev_hi_q           <= cur_q[63:32];
      receiving_d1        <= receiving;
      receiving_d2        <= receiving_d1;
      crc_data            <= '0;
      receiving           <= 1'b0;
      get_terminator      <= 1'b0;
      terminator_location <= '0;
      code_error          <= 1'b0;
      preamble_error      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s0) begin
            if (pre0_ok) begin
              state_q <= DATA;
              align_q <= 1'b0;
            end else begin
              preamble_error <= 1'b1;
            end
          end else if (s4) begin
            if (pre4_ok) begin
              state_q <= PRE_HI;
              align_q <= 1'b1;
            end else begin
              preamble_error <= 1'b1;
            end
          end
        end
        PRE_HI: begin
          if (prehi_ok) begin
            state_q <= DATA;
          end else begin
            preamble_error <= 1'b1;
            state_q        <= IDLE;
          end
        end
        DATA: begin
          if (curc_q == 8'h00) begin
            crc_data  <= aligned;
            receiving <= 1'b1;
          end else if (term_hit) begin
            receiving <= 1'b1;
            // /T/ in the upper half needs one more word
            if (align_q && k_lane[2]) begin
              crc_data <= aligned;
              tloc_q   <= {1'b0, k_lane[1:0]};
              state_q  <= TAIL;
            end else begin
              crc_data            <= mask_bytes(aligned, term_loc);
              get_terminator      <= 1'b1;
              terminator_location <= term_loc;
              state_q             <= IDLE;
            end
          end else begin
            code_error <= 1'b1;
            state_q    <= IDLE;
          end
        end
        TAIL: begin
          crc_data            <= mask_bytes(aligned, tloc_q);
          receiving           <= 1'b1;
          get_terminator      <= 1'b1;
          terminator_location <= tloc_q;
          state_q             <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_xgmii_align.sv
// tb_rx_xgmii_align: scoreboard bench for rx_xgmii_align.
// Frames are built as byte streams; expected words derive from payload.
module tb_rx_xgmii_align;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] rxd = {8{8'h07}};
  logic [7:0]  rxc = 8'hFF;
  logic [63:0] crc_data;
  logic        receiving, receiving_d1, receiving_d2;
  logic        get_terminator, code_error, preamble_error;
  logic [2:0]  terminator_location;

  rx_xgmii_align dut (
    .rxclk               (rxclk),
    .reset               (reset),
    .rxd                 (rxd),
    .rxc                 (rxc),
    .crc_data            (crc_data),
    .receiving           (receiving),
    .receiving_d1        (receiving_d1),
    .receiving_d2        (receiving_d2),
    .get_terminator      (get_terminator),
    .terminator_location (terminator_location),
    .code_error          (code_error),
    .preamble_error      (preamble_error)
  );

  always #5 rxclk = ~rxclk;

  typedef struct {
    logic [2:0]  kind;
    logic [63:0] data;
    logic        term;
    logic [2:0]  loc;
  } exp_t;

  exp_t       sbq[$];
  logic [8:0] sq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  bit h1      = 1'b0;
  bit h2      = 1'b0;
  int rx_cnt  = 0;
  int first_rx = 0;
  int pay_cyc = 0;

  always @(posedge rxclk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge rxclk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      check("rx_d1", 64'(receiving_d1), 64'(h1));
      check("rx_d2", 64'(receiving_d2), 64'(h2));
      check("excl", 64'(get_terminator & (code_error | preamble_error)), 64'd0);
      if (!receiving) begin
        check("idle_data", crc_data, 64'd0);
        check("idle_term", 64'(get_terminator), 64'd0);
      end else begin
        if (rx_cnt == 0) first_rx = cyc;
        rx_cnt++;
      end
      if (receiving | code_error | preamble_error) begin
        if (sbq.size() == 0) begin
          check("unexpected", 64'({receiving, code_error, preamble_error}), 64'd0);
        end else begin
          e = sbq.pop_front();
          check("kind", 64'({receiving, code_error, preamble_error}), 64'(e.kind));
          if (e.kind == 3'b100) begin
            check("data", crc_data, e.data);
            check("term", 64'(get_terminator), 64'(e.term));
            check("loc", 64'(terminator_location), 64'(e.loc));
          end
        end
      end
    end
    h2 = h1;
    h1 = receiving;
  end

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    @(negedge rxclk);
    rxd = d;
    rxc = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_word({8{8'h07}}, 8'hFF);
  endtask

  task automatic drive_stream(input int nmax);
    int w;
    w = 0;
    while (sq.size() >= 8 && w < nmax) begin
      logic [63:0] d;
      logic [7:0]  c;
      logic [8:0]  x;
      for (int b = 0; b < 8; b++) begin
        x = sq.pop_front();
        c[b] = x[8];
        d[8*b +: 8] = x[7:0];
      end
      drive_word(d, c);
      if (w == 1) pay_cyc = cyc;
      w++;
    end
  endtask

  task automatic build_frame(input bit l4, input int len, input int err_pos,
                             input bit bad_sfd, input bit push_exp);
    logic [7:0] pay[$];
    exp_t e;
    int nw;
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    if (l4) repeat (4) sq.push_back({1'b1, 8'h07});
    sq.push_back({1'b1, 8'hFB});
    repeat (6) sq.push_back({1'b0, 8'h55});
    sq.push_back({1'b0, bad_sfd ? 8'hD4 : 8'hD5});
    for (int i = 0; i < len; i++) begin
      if (i == err_pos) break;
      sq.push_back({1'b0, pay[i]});
    end
    sq.push_back(err_pos >= 0 ? {1'b1, 8'hFE} : {1'b1, 8'hFD});
    while (sq.size() % 8 != 0) sq.push_back({1'b1, 8'h07});
    repeat (8) sq.push_back({1'b1, 8'h07});
    if (!push_exp) return;
    e.data = '0; e.term = 1'b0; e.loc = '0;
    if (bad_sfd) begin
      e.kind = 3'b001;
      sbq.push_back(e);
      return;
    end
    nw = (err_pos >= 0) ? err_pos / 8 : len / 8;
    for (int w = 0; w < nw; w++) begin
      e.kind = 3'b100;
      for (int b = 0; b < 8; b++) e.data[8*b +: 8] = pay[8*w + b];
      sbq.push_back(e);
    end
    e.data = '0;
    if (err_pos >= 0) begin
      e.kind = 3'b010;
    end else begin
      e.kind = 3'b100;
      e.term = 1'b1;
      e.loc  = 3'(len % 8);
      for (int b = 0; b < len % 8; b++) e.data[8*b +: 8] = pay[8*nw + b];
    end
    sbq.push_back(e);
  endtask

  task automatic run_frame(input bit l4, input int len, input int err_pos,
                           input bit bad_sfd, output int rxlen);
    rx_cnt = 0;
    build_frame(l4, len, err_pos, bad_sfd, 1'b1);
    drive_stream(1000);
    idle(4);
    check("drain", 64'(sbq.size()), 64'd0);
    sbq.delete();
    rxlen = rx_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: no finish by time limit");
    $fatal(1);
  end

  initial begin
    int n1, n2, n3, n;
    idle(3);
    @(posedge rxclk); #1;
    check("rst_data", crc_data, 64'd0);
    check("rst_rx", 64'({receiving, receiving_d1, receiving_d2}), 64'd0);
    check("rst_pulses", 64'({get_terminator, code_error, preamble_error}), 64'd0);
    check("rst_loc", 64'(terminator_location), 64'd0);
    @(negedge rxclk);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    run_frame(1'b0, 60, -1, 1'b0, n1);
    check("t1_len", 64'(n1), 64'd8);
    check("t1_lat", 64'(first_rx), 64'(pay_cyc + 2));

    run_frame(1'b1, 14, -1, 1'b0, n2);
    check("t2_len", 64'(n2), 64'd2);
    run_frame(1'b1, 18, -1, 1'b0, n3);
    check("t3_longer", 64'(n3), 64'(n2 + 1));

    run_frame(1'b0, 16, -1, 1'b0, n);
    check("t4_len", 64'(n), 64'd3);

    run_frame(1'b0, 40, 11, 1'b0, n);
    check("t5_len", 64'(n), 64'd1);
    run_frame(1'b0, 20, -1, 1'b0, n);
    check("t5_next", 64'(n), 64'd3);

    run_frame(1'b0, 24, -1, 1'b1, n);
    check("t6_len", 64'(n), 64'd0);

    run_frame(1'b1, 16, -1, 1'b0, n);
    check("l4_tail0", 64'(n), 64'd3);
    run_frame(1'b1, 12, -1, 1'b0, n);
    check("l4_loc4", 64'(n), 64'd2);
    run_frame(1'b0, 0, -1, 1'b0, n);
    check("empty", 64'(n), 64'd1);

    for (int i = 0; i < 8; i++) begin
      int len;
      bit l4;
      l4  = 1'($urandom);
      len = 4 + int'($urandom_range(0, 66));
      run_frame(l4, len, -1, 1'b0, n);
      check("rnd_len", 64'(n), 64'(len / 8 + 1));
    end

    mon_en = 1'b0;
    sbq.delete();
    build_frame(1'b0, 40, -1, 1'b0, 1'b0);
    drive_stream(4);
    @(posedge rxclk); #1;
    check("pre_rst_rx", 64'(receiving), 64'd1);
    drive_stream(1);
    reset = 1'b1;
    @(posedge rxclk); #1;
    check("mid_rst_data", crc_data, 64'd0);
    check("mid_rst_rx", 64'({receiving, receiving_d1, receiving_d2}), 64'd0);
    check("mid_rst_pulses", 64'({get_terminator, code_error, preamble_error}), 64'd0);
    drive_stream(2);
    reset  = 1'b0;
    mon_en = 1'b1;
    rx_cnt = 0;
    drive_stream(1000);
    idle(4);
    check("dropped", 64'(rx_cnt), 64'd0);
    run_frame(1'b1, 30, -1, 1'b0, n);
    check("post_rst", 64'(n), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
